// File: rtl/pll_lock_supervisor_pkg.sv
// Shared types and default timing for the rPLL lock supervisor.
// The counter width helper sizes the one timer to the longest interval it must measure.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN,
        FAIL
    } state_e;

    localparam int unsigned DEF_SYNC_STAGES         = 2;
    localparam int unsigned DEF_PLL_RST_CYCLES      = 27;
    localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 27000;
    localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 2700;
    localparam int unsigned DEF_NUM_DOMAINS         = 3;
    localparam int unsigned DEF_STAGE_GAP_CYCLES    = 16;
    localparam int unsigned DEF_MAX_RETRIES         = 3;

    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_lock_sync.sv
// Multi-flop synchronizer for asynchronous status inputs; clears to 0 on reset.
module lock_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Drives rPLL RESET from the crystal clock, waits for a stable lock, then releases
// downstream resets in order; bounded retries end in a sticky fail state.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned SYNC_STAGES         = DEF_SYNC_STAGES,
    parameter int unsigned PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int unsigned NUM_DOMAINS         = DEF_NUM_DOMAINS,
    parameter int unsigned STAGE_GAP_CYCLES    = DEF_STAGE_GAP_CYCLES,
    parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               pll_lock,
    output logic                               pll_reset,
    output logic [NUM_DOMAINS-1:0]             domain_rst_n,
    output logic                               ready,
    output logic                               fail,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count,
    output logic [7:0]                         lock_loss_count,
    output state_e                             dbg_state
);

    localparam int unsigned REL_SPAN = (NUM_DOMAINS - 1) * STAGE_GAP_CYCLES;
    localparam int unsigned CNT_W = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES,
                                              LOCK_STABLE_CYCLES, REL_SPAN + 1);
    localparam int unsigned RTY_W = $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(REL_SPAN);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);
    localparam logic [RTY_W-1:0] RTY_ONE  = RTY_W'(1);

    logic lock_s;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [RTY_W-1:0]       retry_q, retry_d;
    logic [7:0]             loss_q, loss_d;
    logic                   pll_reset_q, pll_reset_d;
    logic [NUM_DOMAINS-1:0] dom_q, dom_d;
    logic                   ready_q, ready_d;
    logic                   fail_q, fail_d;

    lock_sync #(
        .STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (pll_lock),
        .q    (lock_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PLL_RST;
            cnt_q       <= '0;
            retry_q     <= '0;
            loss_q      <= '0;
            pll_reset_q <= 1'b1;
            dom_q       <= '0;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            pll_reset_q <= pll_reset_d;
            dom_q       <= dom_d;
            ready_q     <= ready_d;
            fail_q      <= fail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        case (state_q)
            PLL_RST: begin
                if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                // Lock seen in the expiry cycle still wins over the timeout.
                if (lock_s) begin
                    state_d = STABLE;
                end else if (cnt_q == TO_LAST) begin
                    if (retry_q == RTY_MAX) begin
                        state_d = FAIL;
                    end else begin
                        retry_d = retry_q + RTY_ONE;
                        state_d = PLL_RST;
                    end
                end
            end
            STABLE: begin
                if (!lock_s) state_d = WAIT_LOCK;
                else if (cnt_q == STB_LAST) state_d = RELEASE;
            end
            RELEASE, RUN: begin
                if (!lock_s) begin
                    state_d = PLL_RST;
                    if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
                end else if (state_q == RELEASE && cnt_q == REL_LAST) begin
                    state_d = RUN;
                end
            end
            FAIL: begin
                state_d = FAIL;
            end
            default: begin
                state_d = PLL_RST;
            end
        endcase
        if (state_d == RUN) retry_d = '0;
        cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_ONE;
    end

    // Outputs are decoded from the next state so every output is a flop aligned with state_q.
    always_comb begin
        pll_reset_d = (state_d == PLL_RST) || (state_d == FAIL);
        ready_d     = (state_d == RUN);
        fail_d      = (state_d == FAIL);
        dom_d       = '0;
        if (state_d == RUN) begin
            dom_d = '1;
        end else if (state_d == RELEASE) begin
            for (int unsigned k = 0; k < NUM_DOMAINS; k++) begin
                dom_d[k] = (cnt_d >= CNT_W'(k * STAGE_GAP_CYCLES));
            end
        end
    end

    assign pll_reset       = pll_reset_q;
    assign domain_rst_n    = dom_q;
    assign ready           = ready_q;
    assign fail            = fail_q;
    assign retry_count     = retry_q;
    assign lock_loss_count = loss_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: a per-cycle vector table for bring-up and
// lock loss in RUN, plus hand-written sequences for retry, bounce, reset and saturation.
module tb_pll_lock_supervisor;
    import pll_sup_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       pll_lock;
    logic       pll_reset;
    logic [2:0] domain_rst_n;
    logic       ready;
    logic       fail;
    logic [1:0] retry_count;
    logic [7:0] lock_loss_count;
    state_e     dbg_state;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic       lock;
        logic       exp_reset;
        logic [2:0] exp_dom;
        logic       exp_ready;
        logic [7:0] exp_loss;
    } vec_t;

    typedef struct {
        int         edge_n;
        logic       exp_reset;
        logic [1:0] exp_retry;
        logic       exp_fail;
    } chk_t;

    vec_t vecs[$];
    chk_t chks[$];

    pll_lock_supervisor #(
        .SYNC_STAGES        (2),
        .PLL_RST_CYCLES     (4),
        .LOCK_TIMEOUT_CYCLES(32),
        .LOCK_STABLE_CYCLES (8),
        .NUM_DOMAINS        (3),
        .STAGE_GAP_CYCLES   (2),
        .MAX_RETRIES        (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pll_lock       (pll_lock),
        .pll_reset      (pll_reset),
        .domain_rst_n   (domain_rst_n),
        .ready          (ready),
        .fail           (fail),
        .retry_count    (retry_count),
        .lock_loss_count(lock_loss_count),
        .dbg_state      (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void add(int n, logic lk, logic rs, logic [2:0] dm, logic rd,
                                logic [7:0] ls);
        vec_t v;
        v.lock = lk;
        v.exp_reset = rs;
        v.exp_dom = dm;
        v.exp_ready = rd;
        v.exp_loss = ls;
        repeat (n) vecs.push_back(v);
    endfunction

    function automatic void add_chk(int e, logic rs, logic [1:0] rt, logic fl);
        chk_t c;
        c.edge_n = e;
        c.exp_reset = rs;
        c.exp_retry = rt;
        c.exp_fail = fl;
        chks.push_back(c);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pll_reset"}, pll_reset, 1);
        check({tag, "_dom"}, domain_rst_n, 0);
        check({tag, "_ready"}, ready, 0);
        check({tag, "_fail"}, fail, 0);
        check({tag, "_retry"}, retry_count, 0);
        check({tag, "_loss"}, lock_loss_count, 0);
        check({tag, "_state"}, dbg_state, PLL_RST);
    endtask

    // Holds reset for two cycles, checks reset values, releases on a falling edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        pll_lock = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values(tag);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] got_v;
        logic [15:0] exp_v;
        int          ci;
        int          t;
        rst_n = 1'b0;
        pll_lock = 1'b0;

        // Bring-up, then lock loss in RUN and a full re-acquisition.
        add(3,  0, 1, 3'b000, 0, 0);
        add(10, 0, 0, 3'b000, 0, 0);
        add(10, 1, 0, 3'b000, 0, 0);
        add(2,  1, 0, 3'b001, 0, 0);
        add(2,  1, 0, 3'b011, 0, 0);
        add(1,  1, 0, 3'b111, 0, 0);
        add(2,  1, 0, 3'b111, 1, 0);
        add(2,  0, 0, 3'b111, 1, 0);
        add(1,  0, 1, 3'b000, 0, 1);
        add(3,  0, 1, 3'b000, 0, 1);
        add(10, 1, 0, 3'b000, 0, 1);
        add(2,  1, 0, 3'b001, 0, 1);
        add(2,  1, 0, 3'b011, 0, 1);
        add(1,  1, 0, 3'b111, 0, 1);
        add(2,  1, 0, 3'b111, 1, 1);

        do_reset("por");
        foreach (vecs[i]) begin
            pll_lock = vecs[i].lock;
            cyc(1);
            got_v = {pll_reset, domain_rst_n, ready, fail, retry_count, lock_loss_count};
            exp_v = {vecs[i].exp_reset, vecs[i].exp_dom, vecs[i].exp_ready, 1'b0, 2'b00,
                     vecs[i].exp_loss};
            n_vec++;
            if (got_v !== exp_v) begin
                n_bad++;
                $display("FAIL vec%0d: got reset=%b dom=%b ready=%b fail=%b retry=%0d loss=%0d, expected reset=%b dom=%b ready=%b fail=0 retry=0 loss=%0d",
                         i, pll_reset, domain_rst_n, ready, fail, retry_count, lock_loss_count,
                         vecs[i].exp_reset, vecs[i].exp_dom, vecs[i].exp_ready, vecs[i].exp_loss);
            end
        end

        // Second lock loss, re-acquire into RELEASE, then async reset at dom=011.
        pll_lock = 1'b0;
        cyc(3);
        check("loss2_dom", domain_rst_n, 0);
        check("loss2_pll_reset", pll_reset, 1);
        check("loss2_count", lock_loss_count, 2);
        pll_lock = 1'b1;
        cyc(15);
        check("midrel_dom", domain_rst_n, 3'b011);
        check("midrel_state", dbg_state, RELEASE);
        rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");

        // Lock bounce during STABLE: no retry, fresh 8-cycle run required.
        do_reset("bounce");
        cyc(4);
        check("bounce_wait_reset", pll_reset, 0);
        pll_lock = 1'b1;
        cyc(5);
        check("bounce_stable", dbg_state, STABLE);
        pll_lock = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            check("bounce_low_reset", pll_reset, 0);
        end
        check("bounce_back_wait", dbg_state, WAIT_LOCK);
        pll_lock = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            check("bounce_hold", {pll_reset, domain_rst_n}, 0);
        end
        cyc(1);
        check("bounce_release", domain_rst_n, 3'b001);
        check("bounce_retry", retry_count, 0);

        // Timeout and retry into FAIL with lock held low.
        add_chk(3, 1, 0, 0);    add_chk(4, 0, 0, 0);    add_chk(35, 0, 0, 0);
        add_chk(36, 1, 1, 0);   add_chk(39, 1, 1, 0);   add_chk(40, 0, 1, 0);
        add_chk(71, 0, 1, 0);   add_chk(72, 1, 2, 0);   add_chk(75, 1, 2, 0);
        add_chk(76, 0, 2, 0);   add_chk(107, 0, 2, 0);  add_chk(108, 1, 2, 1);
        add_chk(140, 1, 2, 1);
        do_reset("retry");
        ci = 0;
        for (int e = 1; e <= 140; e++) begin
            cyc(1);
            if (ci < chks.size() && chks[ci].edge_n == e) begin
                check($sformatf("retry_e%0d", e), {pll_reset, retry_count, fail},
                      {chks[ci].exp_reset, chks[ci].exp_retry, chks[ci].exp_fail});
                ci++;
            end
        end
        check("fail_dom", domain_rst_n, 0);
        pll_lock = 1'b1;
        cyc(20);
        check("fail_sticky", {fail, pll_reset, domain_rst_n, ready}, 6'b110000);
        check("fail_state", dbg_state, FAIL);

        // Lock reaching lock_s in the timeout-expiry cycle wins.
        do_reset("tie");
        cyc(33);
        pll_lock = 1'b1;
        cyc(2);
        check("tie_pre_state", dbg_state, WAIT_LOCK);
        cyc(1);
        check("tie_state", dbg_state, STABLE);
        check("tie_retry", retry_count, 0);
        check("tie_pll_reset", pll_reset, 0);

        // Repeated lock drops in RELEASE drive the loss counter into saturation.
        for (int it = 1; it <= 257; it++) begin
            t = 0;
            while (domain_rst_n[0] !== 1'b1 && t < 40) begin
                cyc(1);
                t++;
            end
            if (t == 40) begin
                check("sat_wait_release", 0, 1);
                break;
            end
            pll_lock = 1'b0;
            cyc(3);
            pll_lock = 1'b1;
            if (it == 128) check("sat_128", lock_loss_count, 128);
            if (it == 255) check("sat_255", lock_loss_count, 255);
        end
        check("sat_hold", lock_loss_count, 255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
